// File: rtl/mipi_pkg.sv
// ----------------------------------------------------------------------------
// mipi_pkg
// Shared definitions for the MIPI receive chain: pixel/beat widths, default
// frame geometry and the RGB888 -> RGB565 conversion helpers.
// ----------------------------------------------------------------------------
package mipi_pkg;

  localparam int PIX_W      = 24;                    // {R,G,B}, 8 bits each
  localparam int RGB565_W   = 16;
  localparam int BEAT_PIX   = 4;                     // pixels per input beat
  localparam int BEAT_W     = PIX_W * BEAT_PIX;      // 96-bit RGB888 beat
  localparam int BEAT565_W  = RGB565_W * BEAT_PIX;   // 64-bit RGB565 beat
  localparam int WORD_W     = 2 * BEAT565_W;         // 128-bit DDR word

  // 1280x720 frame, 8 pixels per word.
  localparam int DEF_FRAME_WORDS = 115200;
  localparam int DEF_ADDR_W      = 17;
  localparam int DEF_FIFO_DEPTH  = 4;

  // Truncate each channel to its top bits: {R[7:3], G[7:2], B[7:3]}.
  function automatic logic [RGB565_W-1:0] rgb888_to_565(input logic [PIX_W-1:0] pix);
    return {pix[23:19], pix[15:10], pix[7:3]};
  endfunction

  // Pixel p of the beat lands in field [16p+15:16p] of the result.
  function automatic logic [BEAT565_W-1:0] beat_to_565(input logic [BEAT_W-1:0] beat);
    logic [BEAT565_W-1:0] res;
    res = '0;
    for (int p = 0; p < BEAT_PIX; p++) begin
      res[p*RGB565_W +: RGB565_W] = rgb888_to_565(beat[p*PIX_W +: PIX_W]);
    end
    return res;
  endfunction

endpackage

// File: rtl/mipi_wr_fifo.sv
// ----------------------------------------------------------------------------
// mipi_wr_fifo
// Synchronous first-word fall-through FIFO with a registered head. The head
// register always holds the oldest entry (or zero when empty), so the output
// is glitch-free and stays stable while not popped.
//
// Ports
//   i_clk    clock
//   i_rst    synchronous active-high reset (empties the FIFO, head -> 0)
//   i_push   write i_din; ignored when full unless a pop frees a slot
//   i_din    write data
//   i_pop    consume the head entry; ignored when empty
//   o_full   DEPTH entries stored
//   o_empty  no entry stored (head not valid)
//   o_dout   head entry
// ----------------------------------------------------------------------------
module mipi_wr_fifo #(
  parameter int WIDTH = 145,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_left;       // old entries remaining after this cycle's pop
  logic [WIDTH-1:0] w_head_next;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_dout  = r_head;

  assign w_pop        = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_push       = i_push & (~o_full | w_pop);
  assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_left       = r_count - CNT_W'(w_pop);

  // Next head: the surviving oldest entry, or the incoming word when nothing
  // older is left. When the memory write and this read hit the same slot,
  // w_left is zero and the bypass path is taken instead.
  always_comb begin
    // NOTE: default first so every path assigns w_head_next and no latch is inferred.
    w_head_next = '0;
    if (w_count_next != '0) begin
      w_head_next = (w_left == '0) ? i_din : r_mem[w_rd_next];
    end
  end

  // NOTE: the storage array carries no reset; validity is tracked by r_count,
  // which keeps the array mappable to plain RAM/register banks.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_count  <= w_count_next;
      r_head   <= w_head_next;
    end
  end

endmodule

// File: rtl/mipi_rgb565_ddr_packer.sv
// ----------------------------------------------------------------------------
// mipi_rgb565_ddr_packer
// Converts 4-pixel RGB888 beats to RGB565, packs two beats into one 128-bit
// word with a frame-relative word address and hands the words to the DDR3
// write path through a small FWFT FIFO. V_sync rising edges restart the
// address and flush a pending half word.
//
// Ports
//   I_CLK          byte clock
//   I_Rst          synchronous active-high reset
//   I_V_sync       frame sync level; rising edge starts a frame
//   I_RGB_Vaild    input beat strobe (no backpressure)
//   I_RGB_Data     4 x {R,G,B}, pixel p at [24p+23:24p]
//   O_Wr_Data      8 RGB565 pixels, pixel 0 at [15:0]
//   O_Wr_Addr      frame-relative word address
//   O_Wr_Vaild     word available
//   I_Wr_Ready     consumer accepts the word when O_Wr_Vaild && I_Wr_Ready
//   O_Frame_Start  one-cycle pulse after a V_sync rising edge
//   O_Frame_Done   one-cycle pulse with the last word of a frame
//   O_Overflow     sticky word-dropped flag, cleared by V_sync rising edge
// ----------------------------------------------------------------------------
module mipi_rgb565_ddr_packer
  import mipi_pkg::*;
#(
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              I_CLK,
  input  logic              I_Rst,
  input  logic              I_V_sync,
  input  logic              I_RGB_Vaild,
  input  logic [BEAT_W-1:0] I_RGB_Data,
  output logic [WORD_W-1:0] O_Wr_Data,
  output logic [ADDR_W-1:0] O_Wr_Addr,
  output logic              O_Wr_Vaild,
  input  logic              I_Wr_Ready,
  output logic              O_Frame_Start,
  output logic              O_Frame_Done,
  output logic              O_Overflow
);

  localparam int                ENTRY_W   = WORD_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic                 r_vs_prev;
  logic                 r_half;
  logic [BEAT565_W-1:0] r_a565;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_frame_start;
  logic                 r_frame_done;
  logic                 r_overflow;

  logic [BEAT565_W-1:0] w_beat565;
  logic                 w_rise;
  logic                 w_flush;
  logic                 w_complete;
  logic                 w_push_req;
  logic [WORD_W-1:0]    w_push_data;
  logic                 w_last;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_drop;
  logic [ENTRY_W-1:0]   w_fifo_dout;

  assign w_beat565 = beat_to_565(I_RGB_Data);
  assign w_rise    = I_V_sync & ~r_vs_prev;

  // The edge wins over completion: a pending half word is flushed with a zero
  // upper half, and any beat arriving on the edge opens the new frame.
  assign w_flush     = w_rise & r_half;
  assign w_complete  = I_RGB_Vaild & r_half & ~w_rise;
  assign w_push_req  = w_flush | w_complete;
  assign w_push_data = w_flush ? {{BEAT565_W{1'b0}}, r_a565} : {w_beat565, r_a565};
  assign w_last      = (r_addr == LAST_ADDR);

  assign w_pop  = I_Wr_Ready & ~w_empty;
  // Dropped words still consume an address so the frame geometry holds.
  assign w_drop = w_push_req & w_full & ~w_pop;

  always_ff @(posedge I_CLK) begin
    if (I_Rst) begin
      r_vs_prev     <= 1'b0;
      r_half        <= 1'b0;
      r_a565        <= '0;
      r_addr        <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_vs_prev     <= I_V_sync;
      r_frame_start <= w_rise;
      r_frame_done  <= w_push_req & w_last;

      if (w_rise) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end

      if (w_rise) begin
        r_addr <= '0;
      end else if (w_push_req) begin
        r_addr <= w_last ? '0 : r_addr + ADDR_W'(1);
      end

      if (I_RGB_Vaild && (w_rise || !r_half)) begin
        r_half <= 1'b1;
        r_a565 <= w_beat565;
      end else if (w_push_req) begin
        r_half <= 1'b0;
      end
    end
  end

  mipi_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (I_CLK),
    .i_rst   (I_Rst),
    .i_push  (w_push_req),
    .i_din   ({w_push_data, r_addr}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (w_fifo_dout)
  );

  assign O_Wr_Data     = w_fifo_dout[ENTRY_W-1:ADDR_W];
  assign O_Wr_Addr     = w_fifo_dout[ADDR_W-1:0];
  assign O_Wr_Vaild    = ~w_empty;
  assign O_Frame_Start = r_frame_start;
  assign O_Frame_Done  = r_frame_done;
  assign O_Overflow    = r_overflow;

endmodule

// File: tb/tb_mipi_rgb565_ddr_packer.sv
// ----------------------------------------------------------------------------
// tb_mipi_rgb565_ddr_packer
// Directed bench with a short frame (4 words) so address wrap and frame-done
// are reachable. Inputs change 1 time unit after the rising edge; outputs are
// inspected at the same point, i.e. after the edge that produced them.
// ----------------------------------------------------------------------------
module tb_mipi_rgb565_ddr_packer;

  localparam int ADDR_W = 17;

  logic          I_CLK;
  logic          I_Rst;
  logic          I_V_sync;
  logic          I_RGB_Vaild;
  logic [95:0]   I_RGB_Data;
  logic [127:0]  O_Wr_Data;
  logic [16:0]   O_Wr_Addr;
  logic          O_Wr_Vaild;
  logic          I_Wr_Ready;
  logic          O_Frame_Start;
  logic          O_Frame_Done;
  logic          O_Overflow;

  int checks = 0;
  int errors = 0;

  // Accepted words and frame-done events, gathered at the clock edge.
  logic [16:0]  q_addr [$];
  logic [127:0] q_data [$];
  int           done_cnt;
  logic [16:0]  done_addr;
  logic         done_valid;

  // Hand-converted reference beats.
  localparam logic [95:0]  BEAT_WHITE = 96'hFFFFFF_FFFFFF_FFFFFF_FFFFFF;
  localparam logic [95:0]  BEAT_8040  = 96'h804020_804020_804020_804020;   // 565 = 8204
  localparam logic [95:0]  BEAT_MIXA  = 96'h111111_804020_000000_FFFFFF;   // 1082 8204 0000 FFFF
  localparam logic [95:0]  BEAT_MIXB  = 96'h0000FF_00FF00_FF0000_222222;   // 001F 07E0 F800 2104
  localparam logic [95:0]  BEAT_11    = 96'h111111_111111_111111_111111;
  localparam logic [127:0] W_WHITE    = {128{1'b1}};
  localparam logic [127:0] W_MIX      = 128'h001F_07E0_F800_2104_1082_8204_0000_FFFF;
  localparam logic [127:0] W_FLUSH    = 128'h0000_0000_0000_0000_8204_8204_8204_8204;
  localparam logic [127:0] W_WH_8040  = 128'h8204_8204_8204_8204_FFFF_FFFF_FFFF_FFFF;

  mipi_rgb565_ddr_packer #(
    .FRAME_WORDS (4),
    .ADDR_W      (ADDR_W),
    .FIFO_DEPTH  (4)
  ) dut (
    .I_CLK         (I_CLK),
    .I_Rst         (I_Rst),
    .I_V_sync      (I_V_sync),
    .I_RGB_Vaild   (I_RGB_Vaild),
    .I_RGB_Data    (I_RGB_Data),
    .O_Wr_Data     (O_Wr_Data),
    .O_Wr_Addr     (O_Wr_Addr),
    .O_Wr_Vaild    (O_Wr_Vaild),
    .I_Wr_Ready    (I_Wr_Ready),
    .O_Frame_Start (O_Frame_Start),
    .O_Frame_Done  (O_Frame_Done),
    .O_Overflow    (O_Overflow)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  always @(posedge I_CLK) begin
    if (I_Rst === 1'b0) begin
      if (O_Wr_Vaild === 1'b1 && I_Wr_Ready === 1'b1) begin
        q_addr.push_back(O_Wr_Addr);
        q_data.push_back(O_Wr_Data);
      end
      if (O_Frame_Done === 1'b1) begin
        done_cnt   = done_cnt + 1;
        done_addr  = O_Wr_Addr;
        done_valid = O_Wr_Vaild;
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge I_CLK);
      #1;
    end
  endtask

  // Beat strobe stays high afterwards so consecutive calls form a burst.
  task automatic beat(input logic [95:0] d);
    I_RGB_Vaild = 1'b1;
    I_RGB_Data  = d;
    tick();
  endtask

  task automatic idle(input int n);
    I_RGB_Vaild = 1'b0;
    I_RGB_Data  = '0;
    tick(n);
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    done_cnt   = 0;
    done_addr  = '0;
    done_valid = 1'b0;
  endtask

  task automatic apply_reset();
    I_Rst       = 1'b1;
    I_V_sync    = 1'b0;
    I_RGB_Vaild = 1'b0;
    I_RGB_Data  = '0;
    I_Wr_Ready  = 1'b0;
    tick(2);
    I_Rst = 1'b0;
    clear_log();
  endtask

  task automatic check_addrs(input string name, input int exp_n, input int exp_a [8]);
    checks++;
    if (q_addr.size() !== exp_n) begin
      errors++;
      $display("FAIL %s_count: got %0d words, expected %0d", name, q_addr.size(), exp_n);
    end else begin
      for (int i = 0; i < exp_n; i++) begin
        checks++;
        if (q_addr[i] !== 17'(exp_a[i])) begin
          errors++;
          $display("FAIL %s_addr[%0d]: got %0d expected %0d", name, i, q_addr[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    I_Rst = 1'b1; I_V_sync = 1'b0; I_RGB_Vaild = 1'b0; I_RGB_Data = '0; I_Wr_Ready = 1'b1;
    tick(2);
    checks++; if (O_Wr_Vaild !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b expected 0", O_Wr_Vaild); end
    checks++; if (O_Wr_Data !== '0)       begin errors++; $display("FAIL reset_data: got %h expected 0", O_Wr_Data); end
    checks++; if (O_Wr_Addr !== '0)       begin errors++; $display("FAIL reset_addr: got %0d expected 0", O_Wr_Addr); end
    checks++; if (O_Frame_Start !== 1'b0) begin errors++; $display("FAIL reset_fstart: got %b expected 0", O_Frame_Start); end
    checks++; if (O_Frame_Done !== 1'b0)  begin errors++; $display("FAIL reset_fdone: got %b expected 0", O_Frame_Done); end
    checks++; if (O_Overflow !== 1'b0)    begin errors++; $display("FAIL reset_ovf: got %b expected 0", O_Overflow); end
    I_Rst = 1'b0;
  endtask

  task automatic test_single_word();
    apply_reset();
    I_Wr_Ready = 1'b1;
    beat(BEAT_WHITE);
    checks++; if (O_Wr_Vaild !== 1'b0) begin errors++; $display("FAIL single_early: got valid %b after beat A, expected 0", O_Wr_Vaild); end
    beat(BEAT_WHITE);
    checks++; if (O_Wr_Vaild !== 1'b1)  begin errors++; $display("FAIL single_valid: got %b expected 1", O_Wr_Vaild); end
    checks++; if (O_Wr_Data !== W_WHITE) begin errors++; $display("FAIL single_data: got %h expected %h", O_Wr_Data, W_WHITE); end
    checks++; if (O_Wr_Addr !== 17'd0)   begin errors++; $display("FAIL single_addr: got %0d expected 0", O_Wr_Addr); end
    idle(1);
    checks++; if (O_Wr_Vaild !== 1'b0) begin errors++; $display("FAIL single_pop: got valid %b after accept, expected 0", O_Wr_Vaild); end
  endtask

  task automatic test_conversion();
    apply_reset();
    I_Wr_Ready = 1'b1;
    beat(BEAT_MIXA);
    beat(BEAT_MIXB);
    checks++; if (O_Wr_Data !== W_MIX)   begin errors++; $display("FAIL conv_data: got %h expected %h", O_Wr_Data, W_MIX); end
    checks++; if (O_Wr_Addr !== 17'd0)   begin errors++; $display("FAIL conv_addr: got %0d expected 0", O_Wr_Addr); end
    idle(1);
  endtask

  task automatic test_vsync_flush();
    apply_reset();
    I_Wr_Ready = 1'b1;
    beat(BEAT_WHITE);
    beat(BEAT_WHITE);
    beat(BEAT_8040);
    I_RGB_Vaild = 1'b0;
    I_V_sync    = 1'b1;
    tick();
    checks++; if (O_Wr_Vaild !== 1'b1)    begin errors++; $display("FAIL flush_valid: got %b expected 1", O_Wr_Vaild); end
    checks++; if (O_Wr_Data !== W_FLUSH)  begin errors++; $display("FAIL flush_data: got %h expected %h", O_Wr_Data, W_FLUSH); end
    checks++; if (O_Wr_Addr !== 17'd1)    begin errors++; $display("FAIL flush_addr: got %0d expected 1", O_Wr_Addr); end
    checks++; if (O_Frame_Start !== 1'b1) begin errors++; $display("FAIL flush_fstart: got %b expected 1", O_Frame_Start); end
    checks++; if (O_Frame_Done !== 1'b0)  begin errors++; $display("FAIL flush_fdone: got %b expected 0", O_Frame_Done); end
    tick();
    checks++; if (O_Frame_Start !== 1'b0) begin errors++; $display("FAIL fstart_pulse: got %b expected 0", O_Frame_Start); end
    beat(BEAT_MIXA);
    beat(BEAT_MIXB);
    checks++; if (O_Wr_Addr !== 17'd0)  begin errors++; $display("FAIL newframe_addr: got %0d expected 0", O_Wr_Addr); end
    checks++; if (O_Wr_Data !== W_MIX)  begin errors++; $display("FAIL newframe_data: got %h expected %h", O_Wr_Data, W_MIX); end
    idle(2);
    I_V_sync = 1'b0;
  endtask

  task automatic test_wrap();
    int exp_a [8] = '{0, 1, 2, 3, 0, 0, 0, 0};
    apply_reset();
    I_Wr_Ready = 1'b1;
    for (int i = 0; i < 10; i++) beat(BEAT_WHITE);
    idle(4);
    check_addrs("wrap", 5, exp_a);
    checks++; if (done_cnt !== 1)        begin errors++; $display("FAIL wrap_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (done_addr !== 17'd3)   begin errors++; $display("FAIL wrap_done_addr: got %0d expected 3", done_addr); end
    checks++; if (done_valid !== 1'b1)   begin errors++; $display("FAIL wrap_done_align: got valid %b expected 1", done_valid); end
  endtask

  task automatic test_overflow();
    int exp_a [8] = '{0, 1, 2, 3, 0, 0, 0, 0};
    apply_reset();
    for (int i = 0; i < 12; i++) beat(i == 0 ? BEAT_WHITE : (i == 1 ? BEAT_8040 : 96'h0));
    idle(1);
    checks++; if (O_Overflow !== 1'b1)     begin errors++; $display("FAIL ovf_set: got %b expected 1", O_Overflow); end
    checks++; if (O_Wr_Addr !== 17'd0)     begin errors++; $display("FAIL ovf_head_addr: got %0d expected 0", O_Wr_Addr); end
    checks++; if (O_Wr_Data !== W_WH_8040) begin errors++; $display("FAIL ovf_head_data: got %h expected %h", O_Wr_Data, W_WH_8040); end
    checks++; if (done_cnt !== 1)          begin errors++; $display("FAIL ovf_done_cnt: got %0d expected 1", done_cnt); end
    idle(3);
    checks++; if (O_Wr_Data !== W_WH_8040) begin errors++; $display("FAIL ovf_hold_data: got %h expected %h", O_Wr_Data, W_WH_8040); end
    clear_log();
    I_Wr_Ready = 1'b1;
    tick(6);
    I_Wr_Ready = 1'b0;
    check_addrs("ovf_drain", 4, exp_a);
    if (q_data.size() > 0) begin
      checks++; if (q_data[0] !== W_WH_8040) begin errors++; $display("FAIL ovf_first_data: got %h expected %h", q_data[0], W_WH_8040); end
    end
    checks++; if (O_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", O_Overflow); end
    I_V_sync = 1'b1;
    tick();
    checks++; if (O_Overflow !== 1'b0)    begin errors++; $display("FAIL ovf_clear: got %b expected 0", O_Overflow); end
    checks++; if (O_Frame_Start !== 1'b1) begin errors++; $display("FAIL ovf_fstart: got %b expected 1", O_Frame_Start); end
    I_V_sync = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_a [8] = '{0, 1, 2, 3, 0, 0, 0, 0};
    apply_reset();
    for (int i = 0; i < 8; i++) beat(BEAT_11);
    checks++; if (O_Overflow !== 1'b0) begin errors++; $display("FAIL b2b_full_no_ovf: got %b expected 0", O_Overflow); end
    beat(BEAT_11);
    I_Wr_Ready = 1'b1;        // pop and push on the same edge while full
    beat(BEAT_11);
    idle(6);
    checks++; if (O_Overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", O_Overflow); end
    check_addrs("b2b", 5, exp_a);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) beat(BEAT_11);
    idle(1);
    checks++; if (O_Wr_Vaild !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", O_Wr_Vaild); end
    I_Rst = 1'b1;
    tick();
    checks++; if (O_Wr_Vaild !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", O_Wr_Vaild); end
    checks++; if (O_Wr_Data !== '0)    begin errors++; $display("FAIL rmid_data: got %h expected 0", O_Wr_Data); end
    checks++; if (O_Wr_Addr !== '0)    begin errors++; $display("FAIL rmid_addr: got %0d expected 0", O_Wr_Addr); end
    I_Rst = 1'b0;
    I_Wr_Ready = 1'b1;
    beat(BEAT_WHITE);
    beat(BEAT_8040);
    checks++; if (O_Wr_Vaild !== 1'b1)     begin errors++; $display("FAIL rmid_new_valid: got %b expected 1", O_Wr_Vaild); end
    checks++; if (O_Wr_Addr !== 17'd0)     begin errors++; $display("FAIL rmid_new_addr: got %0d expected 0", O_Wr_Addr); end
    checks++; if (O_Wr_Data !== W_WH_8040) begin errors++; $display("FAIL rmid_new_data: got %h expected %h", O_Wr_Data, W_WH_8040); end
    idle(2);
  endtask

  initial begin
    clear_log();
    test_reset();
    test_single_word();
    test_conversion();
    test_vsync_flush();
    test_wrap();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mipi_rgb565_ddr_packer.md
# mipi_rgb565_ddr_packer

Downstream stage of the MIPI receive chain: consumes the 96-bit, 4-pixel RGB888 beats from the Bayer-to-RGB stage and converts each pixel to RGB565. It packs two beats into one 128-bit word (8 pixels) and attaches a frame-relative word address to each word. Words go to the DDR3 write path over a valid/ready interface through a small FIFO. Frame boundaries come from the unpacker's V_sync.

## Interface
- FRAME_WORDS, 115200: 128-bit words per frame (1280×720/8). Address wraps after FRAME_WORDS-1.
- ADDR_W, 17: width of the word address. Must satisfy 2^ADDR_W ≥ FRAME_WORDS.
- FIFO_DEPTH, 4: output FIFO depth in words. Power of two, ≥2.
- I_CLK  in  1  byte clock; the only clock.
- I_Rst  in  1  synchronous, active-high reset.
- I_V_sync  in  1  frame sync level. Its rising edge starts a frame.
- I_RGB_Vaild  in  1  input beat strobe. There is no backpressure toward upstream.
- I_RGB_Data  in  96  pixel p (0..3) at [24p+23:24p], as {R,G,B} 8 bits each.
- O_Wr_Data  out  128  8 RGB565 pixels. Pixel 0 at [15:0].
- O_Wr_Addr  out  ADDR_W  frame-relative word address.
- O_Wr_Vaild  out  1  word available.
- I_Wr_Ready  in  1  consumer accepts the word when O_Wr_Vaild && I_Wr_Ready.
- O_Frame_Start  out  1  one-cycle pulse, registered, one cycle after a V_sync rising edge.
- O_Frame_Done  out  1  one-cycle pulse when address FRAME_WORDS-1 is pushed or dropped.
- O_Overflow  out  1  sticky. Set when a word is dropped; cleared at the next V_sync rising edge.

## Operation
- Conversion per pixel: {R[7:3], G[7:2], B[7:3]}.
  - One beat yields 64 bits; the pixel p field is [16p+15:16p].
- Packing:
  - Beat A (half flag = 0) is stored in a half register.
  - Beat B completes the word: O_Wr_Data = {B565, A565}.
  - The word is pushed as {data, addr_cnt}, then addr_cnt advances.
- Address counter:
  - Advances by 1 per completed word, including dropped words, so frame geometry is preserved.
  - Wraps FRAME_WORDS-1 → 0. O_Frame_Done pulses on that word.
- V_sync handling: edge detect with a registered previous sample. On a rising-edge cycle:
  - If the half flag is set, push the flush word {64'h0, A565} at addr_cnt.
  - Then addr_cnt←0, half flag←0, O_Overflow←0.
- Beat coinciding with the edge belongs to the new frame. It is stored as beat A at address 0.
- At most one push per cycle. Completion and flush cannot coincide; the edge takes precedence and flushes.
- FIFO full at push time:
  - The word is dropped and O_Overflow←1.
  - The counter and O_Frame_Done still advance.
- Output: first-word fall-through. Head data/address are held stable while O_Wr_Vaild && !I_Wr_Ready.
- Push and pop in the same cycle while full: the pop frees the slot and the push is accepted, no drop.

## Timing
- Reset (I_Rst high at a clock edge):
  - All outputs 0.
  - FIFO emptied, half flag 0, addr_cnt 0, V_sync history 0.
  - Any pending half word is discarded.
- Reset mid-frame: the next frame begins only at a subsequent V_sync rising edge. Beats before it are packed from address 0.
- Latency: second beat sampled at edge N, FIFO empty → O_Wr_Vaild high in cycle N+1.
- O_Frame_Start: high in the cycle after the edge where the V_sync rising edge was sampled.
- O_Frame_Done: registered, same cycle as O_Wr_Vaild for that word, or when the word would have appeared if dropped.
- Throughput: 1 word per 2 input beats. Sustains I_RGB_Vaild every cycle with I_Wr_Ready ≥50%.

## Structure
- Shared package mipi_pkg:
  - RGB565 conversion function.
  - Constants for the 24-bit pixel, 16-bit RGB565 width and 4-pixel beat width.
  - Default frame geometry.
- Sub-module mipi_wr_fifo: synchronous FIFO of width 128+ADDR_W and depth FIFO_DEPTH.
  - Ports push/pop/full/empty.
  - Registered head, first-word fall-through.
- Top holds the converter, half register, address counter, V_sync edge logic and the overflow flag.

## Test plan
- Reset, then 2 beats of all pixels {FF,FF,FF}, I_Wr_Ready=1 → one word 128'hFFFF…FFFF at addr 0, O_Wr_Vaild one cycle after beat 2.
- Pixel {R=0x80,G=0x40,B=0x20} → field 16'h8204. Beats A=0x11…, B=0x22… → A565 occupies low 64 bits.
- Three beats, then V_sync rising → flush word {64'h0, beat3_565} at addr 1. O_Frame_Start pulses. The next 2 beats land at addr 0.
- FRAME_WORDS=4, 10 beats with I_Wr_Ready=1 → addresses 0,1,2,3,0. O_Frame_Done pulses once, on addr 3.
- I_Wr_Ready=0, FIFO_DEPTH=4, 12 continuous beats → words 0..3 held in order, 2 dropped. O_Overflow=1. Addresses after release are 0,1,2,3.
- O_Overflow stays 1 until the next V_sync edge.
- I_Rst asserted mid-word with the FIFO holding 2 words → outputs 0 the next cycle. The next 2 beats produce addr 0.
